off_chip_link_gen: RTL and testbench

Parametrised successor to the fixed 64-bit off-chip link model. It accepts wide words on a valid/ready input and splits each into NFLIT = DATA_W/FLIT_W half-lane-interleaved flits. The flits cross a flit FIFO under credit-based flow control with configurable credit-return latency. On the far side they are reassembled into the original word on a valid/ready output. It sits between the on-chip producer and the off-chip consumer model, and adds input backpressure, an output hold-until-ready rule and a scramble bypass mode.

---
 rtl/off_chip_link_gen_pkg.sv | 31 +++
 rtl/off_chip_link_gen_if.sv | 24 ++
 rtl/off_chip_link_gen_flit_fifo.sv | 43 ++++
 rtl/off_chip_link_gen.sv | 153 +++++++++++++++
 tb/tb_off_chip_link_gen.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/off_chip_link_gen_pkg.sv
// Shared types and width helpers for the off-chip link generator.
// Widths are derived through constant functions so each instance can size itself from its own parameters.
package off_chip_link_pkg;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      SEND = 1'b1
   } tx_state_e;

   function automatic int calc_nflit(input int data_w, input int flit_w);
      return data_w / flit_w;
   endfunction

   function automatic int calc_half(input int flit_w);
      return flit_w / 2;
   endfunction

   // Extra wrap bit distinguishes full from empty.
   function automatic int calc_ptr_w(input int depth);
      return $clog2(depth) + 1;
   endfunction

   function automatic int calc_cred_w(input int depth);
      return $clog2(depth + 1);
   endfunction

   function automatic int calc_idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/off_chip_link_gen_if.sv
// Producer/consumer-facing bundle of the off-chip link: word in, word out, credit view.
interface off_chip_link_gen_if #(
   parameter int DATA_W = 64,
   parameter int DEPTH  = 8
);
   logic                       scramble_en;
   logic [DATA_W-1:0]          data_in;
   logic                       valid_in;
   logic                       ready_in;
   logic [DATA_W-1:0]          data_out;
   logic                       valid_out;
   logic                       ready_out;
   logic [$clog2(DEPTH+1)-1:0] credits;

   modport master (
      output scramble_en, data_in, valid_in, ready_out,
      input  ready_in, data_out, valid_out, credits
   );

   modport slave (
      input  scramble_en, data_in, valid_in, ready_out,
      output ready_in, data_out, valid_out, credits
   );
endinterface

// File: rtl/off_chip_link_gen_flit_fifo.sv
// Flit FIFO: registered write, combinational read, only the pointers are reset.
module link_flit_fifo
   import off_chip_link_pkg::*;
#(
   parameter int DEPTH  = 8,
   parameter int FLIT_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_en,
   input  logic [FLIT_W-1:0] wr_data,
   input  logic              rd_en,
   output logic [FLIT_W-1:0] rd_data,
   output logic              empty
);
   localparam int PW = calc_ptr_w(DEPTH);
   localparam int AW = PW - 1;

   logic [FLIT_W-1:0] mem [DEPTH];
   logic [PW-1:0]     wr_ptr, rd_ptr;
   logic              full, do_wr, do_rd;

   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign do_wr   = wr_en && !full;
   assign do_rd   = rd_en && !empty;
   assign rd_data = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_wr) wr_ptr <= wr_ptr + PW'(1);
         if (do_rd) rd_ptr <= rd_ptr + PW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
   end

endmodule

// File: rtl/off_chip_link_gen.sv
// Wide-word link: TX splits words into flits, flits cross a credit-controlled FIFO,
// RX reassembles them. NFLIT >= 2 and DEPTH >= 2 are assumed.
module off_chip_link_gen
   import off_chip_link_pkg::*;
#(
   parameter int DATA_W     = 64,
   parameter int FLIT_W     = 32,
   parameter int DEPTH      = 8,
   parameter int CREDIT_LAT = 2
) (
   input logic               clk,
   input logic               rst,
   off_chip_link_gen_if.slave lnk
);
   localparam int NFLIT = calc_nflit(DATA_W, FLIT_W);
   localparam int H     = calc_half(FLIT_W);
   localparam int KW    = calc_idx_w(NFLIT);
   localparam int CW    = calc_cred_w(DEPTH);
   localparam logic [KW-1:0] K_LAST   = KW'(NFLIT - 1);
   localparam logic [CW-1:0] CRED_MAX = CW'(DEPTH);

   tx_state_e                    state;
   logic [DATA_W-1:0]            word_q;
   logic [KW-1:0]                k_q;
   logic                         rdy_q;
   logic [CW-1:0]                cred_q;
   logic [CREDIT_LAT-1:0]        cred_pipe;
   logic                         cred_ret;
   logic [NFLIT-1:0][FLIT_W-1:0] tx_flit;
   logic                         fifo_wr, fifo_empty, accept;
   logic [FLIT_W-1:0]            fifo_wdata, fifo_rdata;

   logic [KW-1:0]                krx_q;
   logic [NFLIT-2:0][FLIT_W-1:0] slot_q;
   logic [NFLIT-1:0][FLIT_W-1:0] rx_flit;
   logic [DATA_W-1:0]            scr_word, pln_word, rx_word, dout_q;
   logic                         vout_q, out_free, rx_pop;

   // Per-lane forward and inverse flit mapping.
   for (genvar g = 0; g < NFLIT; g++) begin : g_lane
      assign tx_flit[g] = lnk.scramble_en
                        ? {word_q[DATA_W/2 + g*H +: H], word_q[g*H +: H]}
                        : word_q[g*FLIT_W +: FLIT_W];
      if (g < NFLIT - 1) begin : g_slot
         assign rx_flit[g] = slot_q[g];
      end else begin : g_head
         assign rx_flit[g] = fifo_rdata;
      end
      assign scr_word[DATA_W/2 + g*H +: H] = rx_flit[g][FLIT_W-1:H];
      assign scr_word[g*H +: H]            = rx_flit[g][H-1:0];
      assign pln_word[g*FLIT_W +: FLIT_W]  = rx_flit[g];
   end

   assign rx_word    = lnk.scramble_en ? scr_word : pln_word;
   assign accept     = lnk.valid_in && rdy_q;
   assign fifo_wr    = (state == SEND) && (cred_q != '0);
   assign fifo_wdata = tx_flit[k_q];

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         rdy_q  <= 1'b0;
         k_q    <= '0;
         word_q <= '0;
      end else begin
         case (state)
            IDLE: begin
               rdy_q <= 1'b1;
               if (accept) begin
                  word_q <= lnk.data_in;
                  k_q    <= '0;
                  rdy_q  <= 1'b0;
                  state  <= SEND;
               end
            end
            SEND: begin
               if (fifo_wr) begin
                  if (k_q == K_LAST) begin
                     k_q   <= '0;
                     rdy_q <= 1'b1;
                     state <= IDLE;
                  end else begin
                     k_q <= k_q + KW'(1);
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Each pop travels CREDIT_LAT stages before it is given back to TX.
   assign cred_ret = cred_pipe[CREDIT_LAT-1];

   always_ff @(posedge clk) begin
      if (rst) begin
         cred_q    <= CRED_MAX;
         cred_pipe <= '0;
      end else begin
         cred_pipe[0] <= rx_pop;
         for (int i = 1; i < CREDIT_LAT; i++) cred_pipe[i] <= cred_pipe[i-1];
         case ({fifo_wr, cred_ret})
            2'b10:   cred_q <= cred_q - CW'(1);
            2'b01:   cred_q <= cred_q + CW'(1);
            default: cred_q <= cred_q;
         endcase
      end
   end

   link_flit_fifo #(
      .DEPTH (DEPTH),
      .FLIT_W(FLIT_W)
   ) u_fifo (
      .clk    (clk),
      .rst    (rst),
      .wr_en  (fifo_wr),
      .wr_data(fifo_wdata),
      .rd_en  (rx_pop),
      .rd_data(fifo_rdata),
      .empty  (fifo_empty)
   );

   // The last flit is only taken when the output register can accept the word.
   assign out_free = !vout_q || lnk.ready_out;
   assign rx_pop   = !fifo_empty && ((krx_q != K_LAST) || out_free);

   always_ff @(posedge clk) begin
      if (rst) begin
         krx_q  <= '0;
         slot_q <= '0;
         vout_q <= 1'b0;
         dout_q <= '0;
      end else begin
         if (vout_q && lnk.ready_out) vout_q <= 1'b0;
         if (rx_pop) begin
            if (krx_q == K_LAST) begin
               krx_q  <= '0;
               dout_q <= rx_word;
               vout_q <= 1'b1;
            end else begin
               slot_q[krx_q] <= fifo_rdata;
               krx_q         <= krx_q + KW'(1);
            end
         end
      end
   end

   assign lnk.ready_in  = rdy_q;
   assign lnk.data_out  = dout_q;
   assign lnk.valid_out = vout_q;
   assign lnk.credits   = cred_q;

endmodule

// File: tb/tb_off_chip_link_gen.sv
// Directed bench: three link configurations, queues capture flits and delivered words.
module tb_off_chip_link_gen;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   off_chip_link_gen_if #(.DATA_W(64),  .DEPTH(8)) a_if ();
   off_chip_link_gen_if #(.DATA_W(64),  .DEPTH(2)) b_if ();
   off_chip_link_gen_if #(.DATA_W(128), .DEPTH(8)) c_if ();

   off_chip_link_gen #(.DATA_W(64), .FLIT_W(32), .DEPTH(8), .CREDIT_LAT(2))
      u_a (.clk(clk), .rst(rst), .lnk(a_if));
   off_chip_link_gen #(.DATA_W(64), .FLIT_W(32), .DEPTH(2), .CREDIT_LAT(4))
      u_b (.clk(clk), .rst(rst), .lnk(b_if));
   off_chip_link_gen #(.DATA_W(128), .FLIT_W(32), .DEPTH(8), .CREDIT_LAT(2))
      u_c (.clk(clk), .rst(rst), .lnk(c_if));

   int npass = 0, nfail = 0, ntot = 0;
   logic [63:0]  exp_a[$], rx_a[$], exp_b[$], rx_b[$];
   logic [127:0] exp_c[$], rx_c[$];
   logic [31:0]  flits_a[$], flits_c[$];
   int           bmax = 0;
   logic         b_stall = 1'b0;

   always @(negedge clk) begin
      if (!rst) begin
         if (a_if.valid_out && a_if.ready_out) rx_a.push_back(a_if.data_out);
         if (b_if.valid_out && b_if.ready_out) rx_b.push_back(b_if.data_out);
         if (c_if.valid_out && c_if.ready_out) rx_c.push_back(c_if.data_out);
         if (u_a.fifo_wr) flits_a.push_back(u_a.fifo_wdata);
         if (u_c.fifo_wr) flits_c.push_back(u_c.fifo_wdata);
         if (int'(b_if.credits) > bmax) bmax = int'(b_if.credits);
         if (b_if.credits == 0 && !b_if.ready_in) b_stall = 1'b1;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      ntot++;
      assert (obs === exp) npass++;
      else begin
         nfail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic send_a(input logic [63:0] w);
      int n = 0;
      a_if.data_in = w; a_if.valid_in = 1'b1;
      while (!a_if.ready_in && n < 200) begin tick(); n++; end
      if (n >= 200) chk("a_send_timeout", 0, 1);
      tick(); a_if.valid_in = 1'b0; exp_a.push_back(w);
   endtask

   task automatic send_b(input logic [63:0] w);
      int n = 0;
      b_if.data_in = w; b_if.valid_in = 1'b1;
      while (!b_if.ready_in && n < 200) begin tick(); n++; end
      if (n >= 200) chk("b_send_timeout", 0, 1);
      tick(); b_if.valid_in = 1'b0; exp_b.push_back(w);
   endtask

   task automatic send_c(input logic [127:0] w);
      int n = 0;
      c_if.data_in = w; c_if.valid_in = 1'b1;
      while (!c_if.ready_in && n < 200) begin tick(); n++; end
      if (n >= 200) chk("c_send_timeout", 0, 1);
      tick(); c_if.valid_in = 1'b0; exp_c.push_back(w);
   endtask

   task automatic drain_a(input string tag);
      int n = 0;
      while (rx_a.size() < exp_a.size() && n < 400) begin tick(); n++; end
      chk({tag, "_count"}, rx_a.size(), exp_a.size());
      for (int i = 0; i < exp_a.size(); i++) chk($sformatf("%s_w%0d", tag, i), rx_a[i], exp_a[i]);
      rx_a.delete(); exp_a.delete();
   endtask

   initial begin
      logic [63:0]  w;
      logic [127:0] c1, c2;
      a_if.scramble_en = 1'b1; b_if.scramble_en = 1'b1; c_if.scramble_en = 1'b0;
      a_if.valid_in = 1'b0; b_if.valid_in = 1'b0; c_if.valid_in = 1'b0;
      a_if.data_in = '0; b_if.data_in = '0; c_if.data_in = '0;
      a_if.ready_out = 1'b1; b_if.ready_out = 1'b1; c_if.ready_out = 1'b1;

      // Reset state.
      tick(); tick();
      chk("rst_ready_in", a_if.ready_in, 0);
      chk("rst_valid_out", a_if.valid_out, 0);
      chk("rst_data_out", a_if.data_out, 0);
      chk("rst_credits", a_if.credits, 8);
      chk("rst_credits_b", b_if.credits, 2);
      rst = 1'b0;
      tick();
      chk("post_rst_ready_in", a_if.ready_in, 1);

      // Single word, scramble on: flit order, latency, credit use.
      send_a(64'h0706050403020100);
      chk("t1_ready_in_fall", a_if.ready_in, 0);
      tick();
      tick();
      chk("t1_ready_in_rise", a_if.ready_in, 1);
      chk("t1_valid_early", a_if.valid_out, 0);
      tick();
      chk("t1_valid_out", a_if.valid_out, 1);
      chk("t1_data_out", a_if.data_out, 64'h0706050403020100);
      chk("t1_credits", a_if.credits, 6);
      tick();
      chk("t1_valid_drop", a_if.valid_out, 0);
      chk("t1_flit0", flits_a[0], 32'h05040100);
      chk("t1_flit1", flits_a[1], 32'h07060302);
      drain_a("t1");

      // Back-to-back stream of 16 words.
      for (int i = 0; i < 16; i++) begin
         w = 64'h0123456789ABCDEF ^ (64'h9E3779B97F4A7C15 * 64'(i + 1));
         send_a(w);
      end
      drain_a("t2");
      repeat (6) tick();
      chk("t2_credits_back", a_if.credits, 8);

      // DEPTH=2, CREDIT_LAT=4: credit-limited stalls, no loss.
      for (int i = 0; i < 6; i++) send_b(64'hB000_0000_0000_0000 | 64'(i * 7 + 3));
      begin
         int n = 0;
         while (rx_b.size() < 6 && n < 400) begin tick(); n++; end
      end
      chk("t3_count", rx_b.size(), 6);
      for (int i = 0; i < 6; i++) chk($sformatf("t3_w%0d", i), rx_b[i], exp_b[i]);
      chk("t3_stall_seen", b_stall, 1);
      chk("t3_cred_max", bmax, 2);
      repeat (8) tick();
      chk("t3_credits_back", b_if.credits, 2);

      // 128/32 plain slicing.
      c1 = 128'h0f0e0d0c_0b0a0908_07060504_03020100;
      c2 = 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D;
      send_c(c1);
      send_c(c2);
      begin
         int n = 0;
         while (rx_c.size() < 2 && n < 400) begin tick(); n++; end
      end
      chk("t5_count", rx_c.size(), 2);
      chk("t5_w0", rx_c[0], c1);
      chk("t5_w1", rx_c[1], c2);
      chk("t5_flit0", flits_c[0], 32'h03020100);
      chk("t5_flit1", flits_c[1], 32'h07060504);
      chk("t5_flit2", flits_c[2], 32'h0b0a0908);
      chk("t5_flit3", flits_c[3], 32'h0f0e0d0c);
      chk("t5_flit4", flits_c[4], 32'hCAFEF00D);

      // Output held: six words fill the path until credits run out.
      a_if.ready_out = 1'b0;
      for (int i = 0; i < 6; i++) send_a(64'hA5A5_0000_0000_0000 + 64'(i * 64'h1_0001_0001));
      for (int i = 0; i < 20; i++) begin
         tick();
         chk($sformatf("t4_hold_%0d", i), a_if.data_out, 64'hA5A5_0000_0000_0000);
      end
      chk("t4_valid_held", a_if.valid_out, 1);
      chk("t4_credits_zero", a_if.credits, 0);
      chk("t4_ready_in_low", a_if.ready_in, 0);
      chk("t4_nothing_out", rx_a.size(), 0);
      a_if.ready_out = 1'b1;
      drain_a("t4");

      // Reset with one word in the output, one split and one mid-SEND.
      a_if.ready_out = 1'b0;
      send_a(64'h1111_2222_3333_4444);
      send_a(64'h5555_6666_7777_8888);
      send_a(64'h9999_AAAA_BBBB_CCCC);
      tick();
      rst = 1'b1;
      tick(); tick();
      chk("t6_valid_out", a_if.valid_out, 0);
      chk("t6_data_out", a_if.data_out, 0);
      chk("t6_credits", a_if.credits, 8);
      chk("t6_ready_in_rst", a_if.ready_in, 0);
      rst = 1'b0;
      a_if.ready_out = 1'b1;
      tick();
      chk("t6_ready_in", a_if.ready_in, 1);
      chk("t6_no_output", rx_a.size(), 0);
      exp_a.delete();
      send_a(64'hFEDC_BA98_7654_3210);
      drain_a("t6");

      $display("%0d/%0d checks passed", npass, ntot);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: bench did not finish, %0d/%0d checks passed", npass, ntot);
      $fatal(1, "watchdog");
   end

endmodule
